seq_detector_param: RTL and testbench

// - Parametrised serial pattern detector, successor to the fixed 4-bit "0011" Mealy detector.
// - Matches any LEN-bit pattern, MSB first, on a 1-bit stream sampled on clk_out (divided clock).
// - Overlapping or non-overlapping match mode is selectable at run time.
// - Registered, one-cycle det pulse per match; feeds LED/debug logic in the top-level lab designs.

---
 rtl/seq_det_pkg.sv | 64 ++++++
 rtl/seq_det_hit_counter.sv | 40 ++++
 rtl/seq_detector_param.sv | 110 +++++++++++
 tb/tb_seq_detector_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and elaboration-time helpers for seq_detector_param.
//   MAX_LEN      widest pattern supported (patterns are zero-extended to it)
//   state_width  width of the matched-prefix state, never less than 1 bit
//   pattern_bit  bit idx of a zero-extended pattern (idx 0 = LSB)
//   border_len   longest proper border (prefix that is also a suffix)
//   next_prefix  KMP fallback length after a mismatch at prefix length s
// Related macro: SEQ_DET_COUNT_EN (used by the top, not by this package).
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int MAX_LEN = 16;

  function automatic int state_width(input int len);
    int w;
    w = $clog2(len);
    return (w < 1) ? 1 : w;
  endfunction

  // Shift-based extraction keeps the index arithmetic in plain ints.
  function automatic logic pattern_bit(input logic [MAX_LEN-1:0] pattern, input int idx);
    logic [MAX_LEN-1:0] t;
    t = pattern >> idx;
    return t[0];
  endfunction

  // Bit i of the pattern in transmission order is pattern[len-1-i].
  function automatic int border_len(input logic [MAX_LEN-1:0] pattern, input int len);
    int  best;
    logic ok;
    best = 0;
    for (int k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pattern_bit(pattern, len-1-i) != pattern_bit(pattern, k-1-i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // The observed history is the first s pattern bits followed by b; find the
  // longest suffix of that history (length <= s) that is a pattern prefix.
  function automatic int next_prefix(input logic [MAX_LEN-1:0] pattern, input int len,
                                     input int s, input logic b);
    int   best;
    int   j;
    logic ok;
    logic hb;
    best = 0;
    for (int k = 1; k <= s; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        j  = s + 1 - k + i;
        hb = (j < s) ? pattern_bit(pattern, len-1-j) : b;
        if (hb != pattern_bit(pattern, len-1-i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_hit_counter.sv
// ---------------------------------------------------------------------------
// seq_det_hit_counter
// Saturating match counter for seq_detector_param (only instantiated when
// SEQ_DET_COUNT_EN is defined).
//   clk_out  in   clock
//   rst      in   asynchronous active-high reset
//   clr      in   synchronous clear (wins over inc)
//   inc      in   add one this edge unless already at all-ones
//   cnt      out  CNT_W-bit count
// ---------------------------------------------------------------------------
module seq_det_hit_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
// Parametrised serial pattern detector (KMP prefix automaton), MSB first.
//   clk_out   in   clock (divided clock domain)
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous clear of state, det and counter
//   en        in   sample strobe; inp consumed only when en=1
//   inp       in   serial data bit
//   ovl_mode  in   1 = overlapping matches, 0 = non-overlapping
//   det       out  registered one-cycle match pulse
//   state     out  matched-prefix length 0..LEN-1
//   hit_cnt   out  saturating match count (only with SEQ_DET_COUNT_EN)
// Optional feature macro: SEQ_DET_COUNT_EN.
// ---------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b0011,
  parameter int             CNT_W   = 8,
  localparam int            SW      = state_width(LEN)
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             inp,
  input  logic             ovl_mode,
  output logic             det,
  output logic [SW-1:0]    state
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  localparam int                 SLOTS   = 2 ** SW;
  localparam logic [MAX_LEN-1:0] PAT_EXT = MAX_LEN'(PATTERN);
  localparam int                 BORDER  = border_len(PAT_EXT, LEN);

  if ((LEN < 2) || (LEN > MAX_LEN) || (CNT_W < 1)) begin : g_bad_cfg
    $error("seq_detector_param: LEN must be 2..16 and CNT_W at least 1");
  end

  // Tables are sized to the full state encoding so state_q indexes them
  // directly; slots beyond LEN-1 are unreachable and left at zero.
  logic          exp_bit [SLOTS];
  logic [SW-1:0] fb_tab  [2*SLOTS];

  for (genvar g = 0; g < SLOTS; g++) begin : g_tab
    localparam logic EB  = (g < LEN) ? pattern_bit(PAT_EXT, LEN-1-g) : 1'b0;
    localparam int   FB0 = (g < LEN) ? next_prefix(PAT_EXT, LEN, g, 1'b0) : 0;
    localparam int   FB1 = (g < LEN) ? next_prefix(PAT_EXT, LEN, g, 1'b1) : 0;
    assign exp_bit[g]       = EB;
    assign fb_tab[2*g]      = SW'(FB0);
    assign fb_tab[2*g + 1]  = SW'(FB1);
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          det_q;
  logic          det_d;

  // On a completed match the overlap mode picks between restarting from the
  // pattern border and restarting from scratch.
  always_comb begin
    state_d = state_q;
    det_d   = 1'b0;
    if (clr) begin
      state_d = '0;
    end else if (en) begin
      if (inp == exp_bit[state_q]) begin
        if (state_q == SW'(LEN-1)) begin
          det_d   = 1'b1;
          state_d = ovl_mode ? SW'(BORDER) : '0;
        end else begin
          state_d = state_q + SW'(1);
        end
      end else begin
        state_d = fb_tab[{state_q, inp}];
      end
    end
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
    end
  end

  assign state = state_q;
  assign det   = det_q;

`ifdef SEQ_DET_COUNT_EN
  seq_det_hit_counter #(
    .CNT_W (CNT_W)
  ) u_hit_counter (
    .clk_out (clk_out),
    .rst     (rst),
    .clr     (clr),
    .inc     (det_d),
    .cnt     (hit_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
// Scoreboard bench for seq_detector_param: three instances (0011, 1011 with
// a 2-bit counter, and 3-bit 111) share one input stream. Expected outputs
// come from a history-window model; a monitor compares after every edge.
// Optional feature macro: SEQ_DET_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

  localparam int NI = 3;

  logic clk_out = 1'b0;
  logic rst, clr, en, inp, ovl_mode;
  logic det_a, det_b, det_c;
  logic [1:0] state_a, state_b, state_c;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [7:0] cnt_c;
`endif

  always #5 clk_out = ~clk_out;

  seq_detector_param #(.LEN(4), .PATTERN(4'b0011), .CNT_W(8)) dut_a (
    .clk_out(clk_out), .rst(rst), .clr(clr), .en(en), .inp(inp),
    .ovl_mode(ovl_mode), .det(det_a), .state(state_a)
`ifdef SEQ_DET_COUNT_EN
    , .hit_cnt(cnt_a)
`endif
  );

  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
    .clk_out(clk_out), .rst(rst), .clr(clr), .en(en), .inp(inp),
    .ovl_mode(ovl_mode), .det(det_b), .state(state_b)
`ifdef SEQ_DET_COUNT_EN
    , .hit_cnt(cnt_b)
`endif
  );

  seq_detector_param #(.LEN(3), .PATTERN(3'b111), .CNT_W(8)) dut_c (
    .clk_out(clk_out), .rst(rst), .clr(clr), .en(en), .inp(inp),
    .ovl_mode(ovl_mode), .det(det_c), .state(state_c)
`ifdef SEQ_DET_COUNT_EN
    , .hit_cnt(cnt_c)
`endif
  );

  typedef struct packed {
    logic [2:0]      det;
    logic [2:0][3:0] st;
    logic [2:0][7:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int pat_len [NI] = '{4, 4, 3};
  int pat_val [NI] = '{3, 11, 7};
  int cnt_max [NI] = '{255, 3, 255};

  int h_val [NI];
  int h_len [NI];
  int m_st  [NI];
  int m_cnt [NI];

  int checks = 0;
  int errors = 0;

  // Model: keep the last LEN consumed bits; state is the longest suffix of
  // that window (shorter than LEN) equal to a pattern prefix, and a match is
  // the whole window equal to the pattern. Non-overlap forgets the window.
  task automatic modelStep(input logic r, input logic c, input logic e,
                           input logic b, input logic o, output exp_t ex);
    int d;
    ex = '0;
    for (int i = 0; i < NI; i++) begin
      d = 0;
      if (r || c) begin
        h_val[i] = 0; h_len[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
      end else if (e) begin
        h_val[i] = ((h_val[i] << 1) | int'(b)) & ((1 << pat_len[i]) - 1);
        if (h_len[i] < pat_len[i]) h_len[i]++;
        if (h_len[i] == pat_len[i] && h_val[i] == pat_val[i]) d = 1;
        if (d == 1) begin
          if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
          if (!o) begin
            h_val[i] = 0; h_len[i] = 0;
          end
        end
        m_st[i] = 0;
        for (int k = 1; k < pat_len[i]; k++) begin
          if (k <= h_len[i] && (h_val[i] & ((1 << k) - 1)) == (pat_val[i] >> (pat_len[i] - k)))
            m_st[i] = k;
        end
      end
      ex.det[i] = d[0];
      ex.st[i]  = 4'(m_st[i]);
      ex.cnt[i] = 8'(m_cnt[i]);
    end
  endtask

  task automatic checkOutput(input string name, input int idx, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, expv);
    end
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic e,
                               input logic b, input logic o);
    exp_t ex;
    rst = r; clr = c; en = e; inp = b; ovl_mode = o;
    modelStep(r, c, e, b, o, ex);
    sb_q.push_back(ex);
    @(negedge clk_out);
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n, input logic o);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, bits[i], o);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expectation per rising edge, compared shortly after it.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk_out);
      #1;
      if (sb_q.size() > 0) begin
        ex = sb_q.pop_front();
        checkOutput("det",   0, int'(det_a),   int'(ex.det[0]));
        checkOutput("state", 0, int'(state_a), int'(ex.st[0]));
        checkOutput("det",   1, int'(det_b),   int'(ex.det[1]));
        checkOutput("state", 1, int'(state_b), int'(ex.st[1]));
        checkOutput("det",   2, int'(det_c),   int'(ex.det[2]));
        checkOutput("state", 2, int'(state_c), int'(ex.st[2]));
`ifdef SEQ_DET_COUNT_EN
        checkOutput("hit_cnt", 0, int'(cnt_a), int'(ex.cnt[0]));
        checkOutput("hit_cnt", 1, int'(cnt_b), int'(ex.cnt[1]));
        checkOutput("hit_cnt", 2, int'(cnt_c), int'(ex.cnt[2]));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic o;
    rst = 1'b1; clr = 1'b0; en = 1'b0; inp = 1'b0; ovl_mode = 1'b0;
    @(negedge clk_out);
    repeat (2) doReset();

    sendBits(16'b0011, 4, 1'b0);
    doReset();
    sendBits(16'b1011011, 7, 1'b1);
    doReset();
    sendBits(16'b1011011, 7, 1'b0);
    doReset();
    sendBits(16'b00011, 5, 1'b0);
    doReset();

    // Pattern bits only on enabled edges; noise on the disabled ones.
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0011 >> i, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset pulse with 0011 three bits in, then clear on the completing bit.
    sendBits(16'b001, 3, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    sendBits(16'b001, 3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sendBits(16'b1, 1, 1'b0);

    // Continuous ones for back-to-back matches, then 1011 repeats for saturation.
    sendBits(16'hFFFF, 10, 1'b1);
    for (int i = 0; i < 6; i++) sendBits(16'b1011, 4, 1'b0);

    o = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) o = ~o;
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), o);
    end

    en = 1'b0; clr = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk_out);
    checkOutput("sb_drain", 0, sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
